mpu_xfer_engine: RTL and testbench

//  Synthesizable load/store transfer engine between the memory-side matrix stream and the MPU matrix

---
 rtl/mpu_xfer_engine.sv | 206 ++++++++++++++++++++
 tb/tb_mpu_xfer_engine.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_xfer_engine.sv
// Load/store transfer engine between the memory-side matrix element stream
// and the MPU matrix register file. One transfer at a time; the request is
// size/address checked before the register file is touched.
module mpu_xfer_engine #(
    parameter int DATA_W = 32,
    parameter int M_MAX  = 4,
    parameter int N_MAX  = 4,
    parameter int REGS   = 8,
    localparam int AW    = $clog2(REGS),
    localparam int MW    = $clog2(M_MAX + 1),
    localparam int NW    = $clog2(N_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    // load side
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [MW-1:0]     load_m,
    input  logic [NW-1:0]     load_n,
    input  logic              load_transpose,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_element,
    output logic              load_ack,
    output logic              load_done,
    output logic              load_error,
    output logic              reg_load_en,
    output logic [AW-1:0]     reg_load_addr,
    output logic [MW-1:0]     reg_i_load_loc,
    output logic [NW-1:0]     reg_j_load_loc,
    output logic [DATA_W-1:0] reg_load_element,
    output logic [MW-1:0]     reg_m_load_size,
    output logic [NW-1:0]     reg_n_load_size,
    // store side
    input  logic              store_en,
    input  logic [AW-1:0]     store_addr,
    input  logic [MW-1:0]     store_m,
    input  logic [NW-1:0]     store_n,
    input  logic              store_ready,
    output logic              store_valid,
    output logic [DATA_W-1:0] store_element,
    output logic              store_done,
    output logic              store_error,
    output logic              reg_store_req,
    output logic [AW-1:0]     reg_store_addr,
    output logic [MW-1:0]     reg_i_store_loc,
    output logic [NW-1:0]     reg_j_store_loc,
    input  logic [DATA_W-1:0] reg_store_element
);

    typedef enum logic [2:0] {IDLE, LOAD, ST_RD, ST_WAIT, ST_OUT, DONE} state_t;

    state_t          state, state_d;
    logic [AW-1:0]   addr;
    logic [MW-1:0]   m, i;
    logic [NW-1:0]   n, j;
    logic            tr;
    logic            op_load;   // finished op was a load (selects which request line DONE waits on)

    logic [AW-1:0]   chk_addr;
    logic [MW-1:0]   chk_m;
    logic [NW-1:0]   chk_n;
    logic            chk_ok;
    logic            last;

    // Request check: load has priority over a simultaneous store
    always_comb begin
        chk_addr = load_en ? load_addr : store_addr;
        chk_m    = load_en ? load_m    : store_m;
        chk_n    = load_en ? load_n    : store_n;
        chk_ok   = (chk_m != '0) && (chk_n != '0) &&
                   (chk_m <= MW'(M_MAX)) && (chk_n <= NW'(N_MAX)) &&
                   ({1'b0, chk_addr} < (AW + 1)'(REGS));
        last     = (i == m - MW'(1)) && (j == n - NW'(1));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // Next state and combinational register-file strobes
    always_comb begin
        state_d          = state;
        load_ack         = 1'b0;
        reg_load_en      = 1'b0;
        reg_load_addr    = '0;
        reg_i_load_loc   = '0;
        reg_j_load_loc   = '0;
        reg_load_element = '0;
        reg_m_load_size  = '0;
        reg_n_load_size  = '0;
        reg_store_req    = 1'b0;
        reg_store_addr   = '0;
        reg_i_store_loc  = '0;
        reg_j_store_loc  = '0;
        case (state)
            IDLE: begin
                if (load_en || store_en)
                    state_d = !chk_ok ? DONE : (load_en ? LOAD : ST_RD);
            end
            LOAD: begin
                load_ack = 1'b1;
                if (load_valid) begin
                    reg_load_en      = 1'b1;
                    reg_load_addr    = addr;
                    reg_load_element = load_element;
                    reg_i_load_loc   = tr ? MW'(j) : i;
                    reg_j_load_loc   = tr ? NW'(i) : j;
                    reg_m_load_size  = tr ? MW'(n) : m;
                    reg_n_load_size  = tr ? NW'(m) : n;
                    if (last) state_d = DONE;
                end
            end
            ST_RD: begin
                reg_store_req   = 1'b1;
                reg_store_addr  = addr;
                reg_i_store_loc = i;
                reg_j_store_loc = j;
                state_d         = ST_WAIT;
            end
            ST_WAIT: state_d = ST_OUT;
            ST_OUT: begin
                if (store_ready) state_d = last ? DONE : ST_RD;
            end
            DONE: begin
                if (op_load ? !load_en : !store_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latched request, element counters, output element and status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr          <= '0;
            m             <= '0;
            n             <= '0;
            i             <= '0;
            j             <= '0;
            tr            <= 1'b0;
            op_load       <= 1'b0;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
            store_done    <= 1'b0;
            store_error   <= 1'b0;
            store_valid   <= 1'b0;
            store_element <= '0;
        end else begin
            load_done   <= 1'b0;
            load_error  <= 1'b0;
            store_done  <= 1'b0;
            store_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_en || store_en) begin
                        op_load <= load_en;
                        if (chk_ok) begin
                            addr <= chk_addr;
                            m    <= chk_m;
                            n    <= chk_n;
                            tr   <= load_en && load_transpose;
                            i    <= '0;
                            j    <= '0;
                        end else if (load_en) begin
                            load_error <= 1'b1;
                        end else begin
                            store_error <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (load_valid) begin
                        if (last) begin
                            load_done <= 1'b1;
                        end else if (j == n - NW'(1)) begin
                            j <= '0;
                            i <= i + MW'(1);
                        end else begin
                            j <= j + NW'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    store_element <= reg_store_element;
                    store_valid   <= 1'b1;
                end
                ST_OUT: begin
                    if (store_ready) begin
                        store_valid <= 1'b0;
                        if (last) begin
                            store_done <= 1'b1;
                        end else if (j == n - NW'(1)) begin
                            j <= '0;
                            i <= i + MW'(1);
                        end else begin
                            j <= j + NW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_xfer_engine.sv
// Directed bench for mpu_xfer_engine: normal and transposed loads, store with
// backpressure, rejected requests, load/store contention and mid-transfer reset.
module tb_mpu_xfer_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        load_en = 0, load_transpose = 0, load_valid = 0;
    logic [2:0]  load_addr = 0, load_m = 0, load_n = 0;
    logic [31:0] load_element = 0;
    logic        load_ack, load_done, load_error, reg_load_en;
    logic [2:0]  reg_load_addr, reg_i_load_loc, reg_j_load_loc, reg_m_load_size, reg_n_load_size;
    logic [31:0] reg_load_element;
    logic        store_en = 0, store_ready = 0;
    logic [2:0]  store_addr = 0, store_m = 0, store_n = 0;
    logic        store_valid, store_done, store_error, reg_store_req;
    logic [31:0] store_element;
    logic [2:0]  reg_store_addr, reg_i_store_loc, reg_j_store_loc;
    logic [31:0] reg_store_element = 0;

    int total = 0;
    int passed = 0;

    mpu_xfer_engine dut (
        .clk(clk), .rst(rst),
        .load_en(load_en), .load_addr(load_addr), .load_m(load_m), .load_n(load_n),
        .load_transpose(load_transpose), .load_valid(load_valid), .load_element(load_element),
        .load_ack(load_ack), .load_done(load_done), .load_error(load_error),
        .reg_load_en(reg_load_en), .reg_load_addr(reg_load_addr),
        .reg_i_load_loc(reg_i_load_loc), .reg_j_load_loc(reg_j_load_loc),
        .reg_load_element(reg_load_element),
        .reg_m_load_size(reg_m_load_size), .reg_n_load_size(reg_n_load_size),
        .store_en(store_en), .store_addr(store_addr), .store_m(store_m), .store_n(store_n),
        .store_ready(store_ready), .store_valid(store_valid), .store_element(store_element),
        .store_done(store_done), .store_error(store_error),
        .reg_store_req(reg_store_req), .reg_store_addr(reg_store_addr),
        .reg_i_store_loc(reg_i_store_loc), .reg_j_store_loc(reg_j_store_loc),
        .reg_store_element(reg_store_element)
    );

    // Register-file read model: element (a,i,j) reads as 0x100 + 16a + 4i + j, one cycle after the request
    always @(posedge clk)
        if (reg_store_req)
            reg_store_element <= 32'h100 + 32'(reg_store_addr) * 16 + 32'(reg_i_store_loc) * 4
                                 + 32'(reg_j_store_loc);

    task automatic test_reset();
        #12;
        total++;
        if ({load_ack, load_done, load_error, reg_load_en, store_valid, store_done, store_error,
             reg_store_req} !== 8'h00 || store_element !== 32'h0)
            $display("FAIL reset_outputs: got ctl=%b elem=%h, want 0", {load_ack, load_done, load_error,
                     reg_load_en, store_valid, store_done, store_error, reg_store_req}, store_element);
        else passed++;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    // 2x3 load of elements 1..6, optionally transposed
    task automatic test_load_2x3(input logic [2:0] a, input logic tr);
        int er[6], ec[6];
        int k = 0, dn = 0, bad = 0;
        logic [2:0] ems, ens;
        if (tr) begin er = '{0, 1, 2, 0, 1, 2}; ec = '{0, 0, 0, 1, 1, 1}; ems = 3; ens = 2; end
        else    begin er = '{0, 0, 0, 1, 1, 1}; ec = '{0, 1, 2, 0, 1, 2}; ems = 2; ens = 3; end
        @(negedge clk);
        load_en = 1; load_addr = a; load_m = 2; load_n = 3; load_transpose = tr;
        load_valid = 1; load_element = 1;
        for (int cyc = 0; cyc < 40 && dn == 0; cyc++) begin
            #1;
            if (reg_load_en) begin
                total++;
                if (k >= 6) begin
                    $display("FAIL load_extra_write tr=%0d: got write #%0d, want 6 writes", tr, k + 1);
                end else if (reg_i_load_loc !== 3'(er[k]) || reg_j_load_loc !== 3'(ec[k]) ||
                             reg_load_element !== 32'(k + 1) || reg_load_addr !== a ||
                             reg_m_load_size !== ems || reg_n_load_size !== ens) begin
                    $display("FAIL load_write tr=%0d k=%0d: got (%0d,%0d) d=%0d a=%0d sz=%0dx%0d, want (%0d,%0d) d=%0d a=%0d sz=%0dx%0d",
                             tr, k, reg_i_load_loc, reg_j_load_loc, reg_load_element, reg_load_addr,
                             reg_m_load_size, reg_n_load_size, er[k], ec[k], k + 1, a, ems, ens);
                end else passed++;
                k++;
            end
            if (load_done) begin
                dn = 1;
                if (load_ack) bad++;
            end
            @(negedge clk);
            load_element = 32'(k + 1);
        end
        total++;
        if (k !== 6 || dn !== 1 || bad !== 0)
            $display("FAIL load_complete tr=%0d: got writes=%0d done=%0d ack_at_done=%0d, want 6 1 0", tr, k, dn, bad);
        else passed++;
        // hold load_en one cycle in DONE, then release; no further activity expected
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (reg_load_en || load_done || load_ack) bad++;
            @(negedge clk);
            load_en = 0;
        end
        load_valid = 0;
        total++;
        if (bad !== 0) $display("FAIL load_quiet tr=%0d: got %0d active cycles, want 0", tr, bad);
        else passed++;
    endtask

    // Store 2x2 from reg 1 with store_ready pattern 1,0,0,1
    task automatic test_store_backpressure();
        logic [31:0] exp[4] = '{32'h110, 32'h111, 32'h114, 32'h115};
        logic rp[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int k = 0, dn = 0, hold_bad = 0, addr_bad = 0;
        logic prev_v = 0, prev_hs = 0;
        logic [31:0] prev_e = 0;
        @(negedge clk);
        store_en = 1; store_addr = 1; store_m = 2; store_n = 2;
        for (int cyc = 0; cyc < 80 && dn == 0; cyc++) begin
            store_ready = rp[cyc % 4];
            #1;
            if (prev_v && !prev_hs && (store_valid !== 1'b1 || store_element !== prev_e)) hold_bad++;
            if (reg_store_req && reg_store_addr !== 3'd1) addr_bad++;
            if (store_valid && store_ready) begin
                total++;
                if (k >= 4) $display("FAIL store_extra: got element #%0d, want 4", k + 1);
                else if (store_element !== exp[k])
                    $display("FAIL store_elem k=%0d: got %h, want %h", k, store_element, exp[k]);
                else passed++;
                k++;
            end
            if (store_done) dn = 1;
            prev_v = store_valid; prev_e = store_element; prev_hs = store_valid && store_ready;
            @(negedge clk);
        end
        total++;
        if (k !== 4 || dn !== 1 || hold_bad !== 0 || addr_bad !== 0)
            $display("FAIL store_complete: got n=%0d done=%0d hold_bad=%0d addr_bad=%0d, want 4 1 0 0",
                     k, dn, hold_bad, addr_bad);
        else passed++;
        store_en = 0; store_ready = 0;
        @(negedge clk); @(negedge clk);
    endtask

    // Rejected requests: load m=5, store m=0, store n=5
    task automatic test_errors();
        int lerr = 0, serr = 0, first = -1, bad = 0;
        @(negedge clk);
        load_en = 1; load_addr = 0; load_m = 5; load_n = 2; load_valid = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (load_error) begin lerr++; if (first < 0) first = c; end
            if (reg_load_en || load_ack || load_done || reg_store_req) bad++;
        end
        total++;
        if (lerr !== 1 || first !== 0 || bad !== 0)
            $display("FAIL load_error: got pulses=%0d at=%0d activity=%0d, want 1 0 0", lerr, first, bad);
        else passed++;
        load_en = 0; load_valid = 0;
        @(negedge clk); @(negedge clk);
        for (int t = 0; t < 2; t++) begin
            serr = 0; bad = 0;
            store_en = 1; store_addr = 2; store_m = (t == 0) ? 3'd0 : 3'd1;
            store_n = (t == 0) ? 3'd2 : 3'd5; store_ready = 1;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk); #1;
                if (store_error) serr++;
                if (reg_store_req || store_valid || store_done || reg_load_en) bad++;
            end
            total++;
            if (serr !== 1 || bad !== 0)
                $display("FAIL store_error t=%0d: got pulses=%0d activity=%0d, want 1 0", t, serr, bad);
            else passed++;
            store_en = 0; store_ready = 0;
            @(negedge clk); @(negedge clk);
        end
    endtask

    // load_en and store_en rise together: 1x2 load to reg 3 completes before 1x1 store from reg 3
    task automatic test_back_to_back();
        int lw = 0, bad = 0, ldc = -1, sdc = -1;
        logic [31:0] sel = 0;
        @(negedge clk);
        load_en = 1; load_addr = 3; load_m = 1; load_n = 2; load_transpose = 0;
        load_valid = 1; load_element = 32'h11;
        store_en = 1; store_addr = 3; store_m = 1; store_n = 1; store_ready = 1;
        for (int cyc = 0; cyc < 40 && sdc < 0; cyc++) begin
            #1;
            if (reg_store_req && load_en) bad++;
            if (reg_load_en) begin
                if (reg_load_element !== 32'h11 + 32'(lw) || reg_i_load_loc !== 3'd0 ||
                    reg_j_load_loc !== 3'(lw)) bad++;
                lw++;
            end
            if (load_done) ldc = cyc;
            if (store_valid && store_ready) sel = store_element;
            if (store_done) sdc = cyc;
            @(negedge clk);
            load_element = 32'h11 + 32'(lw);
            if (ldc >= 0) load_en = 0;
        end
        total++;
        if (lw !== 2 || bad !== 0 || ldc < 0 || sdc <= ldc)
            $display("FAIL contention_order: got writes=%0d bad=%0d load_done@%0d store_done@%0d, want 2 0 load first",
                     lw, bad, ldc, sdc);
        else passed++;
        total++;
        if (sel !== 32'h130) $display("FAIL contention_store: got %h, want 00000130", sel);
        else passed++;
        store_en = 0; store_ready = 0; load_valid = 0;
        @(negedge clk); @(negedge clk);
    endtask

    // Reset after the 3rd of 6 load elements, then a fresh 1x1 load
    task automatic test_reset_abort();
        int k = 0, dn = 0, bad = 0;
        @(negedge clk);
        load_en = 1; load_addr = 4; load_m = 2; load_n = 3; load_valid = 1; load_element = 1;
        for (int cyc = 0; cyc < 20 && k < 3; cyc++) begin
            #1;
            if (reg_load_en) k++;
            @(negedge clk);
            load_element = 32'(k + 1);
        end
        rst = 0;
        #1;
        total++;
        if (k !== 3 || {load_ack, load_done, load_error, reg_load_en, store_valid, store_done,
                        store_error, reg_store_req} !== 8'h00 ||
            |{reg_load_addr, reg_i_load_loc, reg_j_load_loc, reg_load_element} !== 1'b0)
            $display("FAIL reset_abort: got writes=%0d ack=%b wr=%b loc=(%0d,%0d), want 3 0 0 (0,0)",
                     k, load_ack, reg_load_en, reg_i_load_loc, reg_j_load_loc);
        else passed++;
        load_en = 0;
        @(negedge clk); rst = 1;
        @(negedge clk);
        load_en = 1; load_addr = 5; load_m = 1; load_n = 1; load_element = 32'hAB;
        k = 0;
        for (int cyc = 0; cyc < 20 && dn == 0; cyc++) begin
            #1;
            if (reg_load_en) begin
                if (reg_load_addr !== 3'd5 || reg_i_load_loc !== 3'd0 || reg_j_load_loc !== 3'd0 ||
                    reg_load_element !== 32'hAB || reg_m_load_size !== 3'd1 || reg_n_load_size !== 3'd1) bad++;
                k++;
            end
            if (load_done) dn = 1;
            @(negedge clk);
        end
        total++;
        if (k !== 1 || dn !== 1 || bad !== 0)
            $display("FAIL post_reset_load: got writes=%0d done=%0d bad=%0d, want 1 1 0", k, dn, bad);
        else passed++;
        load_en = 0; load_valid = 0;
        @(negedge clk); @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load_2x3(3'd1, 1'b0);
        test_load_2x3(3'd2, 1'b1);
        test_store_backpressure();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
